kmer_window: RTL and testbench

- Upstream feeder for the hash stage.
- Accepts packed 2-bit nucleotide words from the read-fetch path and slides a K-base window over each read.
- Presents one K-mer key per cycle on key/ctr, which wire directly to the hash stage's key/ctr_in inputs.
- Honours the same stall the hash stage sees. Keys never span two reads; each read ends with an end-of-read marker.

---
 rtl/kmer_window_if.sv | 14 +
 rtl/kmer_window.sv | 147 ++++++++++++++
 tb/tb_kmer_window.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmer_window_if.sv
// Input word stream from the read-fetch path into kmer_window.
// The master drives a packed word of 2-bit bases; the slave answers with in_ready.
interface kmer_window_if #(
   parameter int IN_BASES = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2*IN_BASES-1:0] in_data;
   logic [5:0]            in_nbases;
   logic                  in_last;

   modport master (output in_valid, in_data, in_nbases, in_last, input in_ready);
   modport slave  (input in_valid, in_data, in_nbases, in_last, output in_ready);
endinterface

// File: rtl/kmer_window.sv
// kmer_window: slides a K-base window over each read and presents one K-mer key
// per unstalled cycle to the hash stage. Keys never span two reads; every read
// is closed by an end-of-read marker (ctr=01, key=0).
module kmer_window #(
   parameter int K        = 100,
   parameter int IN_BASES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   kmer_window_if.slave      in_if,
   output logic [2*K-1:0]    key,
   output logic [1:0]        ctr
);
   localparam int KW = 2 * K;
   localparam int DW = 2 * IN_BASES;
   localparam int IW = $clog2(IN_BASES + 1);
   localparam int FW = $clog2(K + 1);
   localparam int CW = (IW > 6) ? IW + 1 : 7;

   localparam logic [1:0] CTR_NONE = 2'b00;
   localparam logic [1:0] CTR_KEY  = 2'b11;
   localparam logic [1:0] CTR_EOR  = 2'b01;

   // Word buffer: one captured input word plus the index of the next base to consume.
   logic [DW-1:0] buf_data_q, buf_data_d;
   logic [5:0]    buf_n_q, buf_n_d;
   logic [IW-1:0] buf_idx_q, buf_idx_d;
   logic          buf_full_q, buf_full_d;
   logic          buf_last_q, buf_last_d;
   logic          pend_last_q, pend_last_d;
   logic          live_q;

   // Only the newest K-1 bases are kept; the key is formed from these plus the incoming base.
   logic [KW-3:0] win_q, win_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [KW-1:0] key_q, key_d;
   logic [1:0]    ctr_q, ctr_d;

   logic [1:0]    base_s;
   logic [KW-1:0] win_shift_s;
   logic [FW-1:0] fill_inc_s;
   logic [CW-1:0] idx_next_s;
   logic          last_base_s;
   logic          take_s;

   // live_q keeps in_ready low until the first edge after reset is released.
   assign in_if.in_ready = rst & live_q & ~buf_full_q & ~pend_last_q & ~stall;
   assign take_s         = in_if.in_valid & in_if.in_ready;

   assign win_shift_s = {win_q, base_s};
   assign fill_inc_s  = (fill_q == FW'(K)) ? fill_q : (fill_q + FW'(1));
   assign idx_next_s  = CW'(buf_idx_q) + CW'(1);
   // Treat an index at or past the word length as the last base so nothing beyond it is taken.
   assign last_base_s = (idx_next_s >= CW'(buf_n_q));

   assign key = key_q;
   assign ctr = ctr_q;

   // Select the base at the current buffer index (OR of one-hot matches).
   always_comb begin
      base_s = 2'b00;
      for (int i = 0; i < IN_BASES; i++) begin
         base_s = base_s | ((IW'(i) == buf_idx_q) ? buf_data_q[2*i +: 2] : 2'b00);
      end
   end

   // Next-state: end-of-read marker, base consumption, or word capture; stall holds everything.
   always_comb begin
      buf_data_d  = buf_data_q;
      buf_n_d     = buf_n_q;
      buf_idx_d   = buf_idx_q;
      buf_full_d  = buf_full_q;
      buf_last_d  = buf_last_q;
      pend_last_d = pend_last_q;
      win_d       = win_q;
      fill_d      = fill_q;
      key_d       = key_q;
      ctr_d       = ctr_q;

      if (stall) begin
         ctr_d = ctr_q;
      end else if (pend_last_q) begin
         ctr_d       = CTR_EOR;
         key_d       = '0;
         win_d       = '0;
         fill_d      = '0;
         pend_last_d = 1'b0;
      end else if (buf_full_q) begin
         win_d  = win_shift_s[KW-3:0];
         fill_d = fill_inc_s;
         if (fill_inc_s == FW'(K)) begin
            ctr_d = CTR_KEY;
            key_d = win_shift_s;
         end else begin
            ctr_d = CTR_NONE;
         end
         if (last_base_s) begin
            buf_full_d  = 1'b0;
            buf_idx_d   = '0;
            pend_last_d = buf_last_q;
         end else begin
            buf_idx_d = IW'(idx_next_s);
         end
      end else begin
         ctr_d = CTR_NONE;
         if (take_s) begin
            buf_data_d = in_if.in_data;
            buf_n_d    = in_if.in_nbases;
            buf_last_d = in_if.in_last;
            buf_full_d = 1'b1;
            buf_idx_d  = '0;
         end else begin
            buf_full_d = 1'b0;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_data_q  <= '0;
         buf_n_q     <= 6'd0;
         buf_idx_q   <= '0;
         buf_full_q  <= 1'b0;
         buf_last_q  <= 1'b0;
         pend_last_q <= 1'b0;
         live_q      <= 1'b0;
         win_q       <= '0;
         fill_q      <= '0;
         key_q       <= '0;
         ctr_q       <= CTR_NONE;
      end else begin
         buf_data_q  <= buf_data_d;
         buf_n_q     <= buf_n_d;
         buf_idx_q   <= buf_idx_d;
         buf_full_q  <= buf_full_d;
         buf_last_q  <= buf_last_d;
         pend_last_q <= pend_last_d;
         live_q      <= 1'b1;
         win_q       <= win_d;
         fill_q      <= fill_d;
         key_q       <= key_d;
         ctr_q       <= ctr_d;
      end
   end
endmodule

// File: tb/tb_kmer_window.sv
// Self-checking bench for kmer_window: a K=4 and a default K=100 instance,
// table-driven reads plus hand-written stall / reset / back-to-back sequences,
// with a scoreboard queue of expected non-idle outputs per instance.
module tb_kmer_window;
   typedef struct {
      logic [1:0]   ctr;
      logic [199:0] key;
   } exp_t;

   typedef struct {
      int len;
      int wsz;
      int exp_keys;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall4 = 1'b0;
   logic stall100 = 1'b0;
   logic [7:0]   key4;
   logic [1:0]   ctr4;
   logic [199:0] key100;
   logic [1:0]   ctr100;

   int n_vec = 0;
   int n_bad = 0;
   int keys4 = 0;
   int keys100 = 0;
   logic abort = 1'b0;
   logic adv4_q = 1'b0;
   logic adv100_q = 1'b0;
   logic got100 = 1'b0;
   logic [199:0] first100;
   exp_t q4[$];
   exp_t q100[$];
   logic [1:0] bases [0:255];

   kmer_window_if #(.IN_BASES(32)) if4 ();
   kmer_window_if #(.IN_BASES(32)) if100 ();

   kmer_window #(.K(4), .IN_BASES(32)) u4 (
      .clk(clk), .rst(rst), .stall(stall4), .in_if(if4), .key(key4), .ctr(ctr4));
   kmer_window #(.K(100), .IN_BASES(32)) u100 (
      .clk(clk), .rst(rst), .stall(stall100), .in_if(if100), .key(key100), .ctr(ctr100));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Remember which edges actually advanced each DUT (not reset, not stalled).
   always @(posedge clk) begin
      adv4_q   <= rst && !stall4;
      adv100_q <= rst && !stall100;
   end

   // Scoreboard: every non-idle output produced on an advancing edge is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (adv4_q && ctr4 != 2'b00) begin
         if (ctr4 == 2'b11) keys4++;
         if (q4.size() == 0) begin
            chk("k4_extra_output", 256'(ctr4), 256'(0));
         end else begin
            e = q4.pop_front();
            chk("k4_ctr", 256'(ctr4), 256'(e.ctr));
            chk("k4_key", 256'(key4), 256'(e.key));
         end
      end
      if (adv100_q && ctr100 != 2'b00) begin
         if (ctr100 == 2'b11) begin
            keys100++;
            if (!got100) begin
               first100 = key100;
               got100   = 1'b1;
            end
         end
         if (q100.size() == 0) begin
            chk("k100_extra_output", 256'(ctr100), 256'(0));
         end else begin
            e = q100.pop_front();
            chk("k100_ctr", 256'(ctr100), 256'(e.ctr));
            chk("k100_key", 256'(key100), 256'(e.key));
         end
      end
   end

   task automatic set_in(input int sel, input logic v, input logic [63:0] d, input logic [5:0] n,
                         input logic l);
      if (sel == 0) begin
         if4.in_valid = v; if4.in_data = d; if4.in_nbases = n; if4.in_last = l;
      end else begin
         if100.in_valid = v; if100.in_data = d; if100.in_nbases = n; if100.in_last = l;
      end
   endtask

   function automatic logic can_xfer(input int sel);
      return (sel == 0) ? (if4.in_ready && !stall4) : (if100.in_ready && !stall100);
   endfunction

   task automatic fill_bases(input int len);
      for (int i = 0; i < len; i++) bases[i] = 2'($urandom_range(3, 0));
   endtask

   // Reference: sliding window of the last K bases, one key per full window, then a marker.
   task automatic push_model(input int sel, input int len);
      logic [199:0] w;
      exp_t e;
      int kk;
      kk = (sel == 0) ? 4 : 100;
      w  = '0;
      for (int i = 0; i < len; i++) begin
         w = {w[197:0], bases[i]};
         if (sel == 0) w[199:8] = '0;
         if (i >= kk - 1) begin
            e.ctr = 2'b11; e.key = w;
            if (sel == 0) q4.push_back(e); else q100.push_back(e);
         end
      end
      e.ctr = 2'b01; e.key = '0;
      if (sel == 0) q4.push_back(e); else q100.push_back(e);
   endtask

   // Drive a read of len bases from bases[] in words of up to wsz bases.
   task automatic drive_read(input int sel, input int len, input int wsz);
      int pos, n, t;
      logic to;
      logic [63:0] d;
      pos = 0;
      to  = 1'b0;
      while (pos < len && !abort) begin
         n = (len - pos < wsz) ? (len - pos) : wsz;
         d = '0;
         for (int j = 0; j < n; j++) d[2*j +: 2] = bases[pos + j];
         @(negedge clk);
         set_in(sel, 1'b1, d, 6'(n), (pos + n == len));
         #2;
         t = 0;
         while (!can_xfer(sel) && !abort && !to) begin
            @(negedge clk); #2;
            t++;
            if (t > 400) begin
               to = 1'b1;
               chk("handshake_timeout", 256'(1), 256'(0));
            end
         end
         if (abort || to) break;
         @(posedge clk);
         pos += n;
      end
      @(negedge clk);
      set_in(sel, 1'b0, 64'd0, 6'd0, 1'b0);
   endtask

   task automatic drain(input int sel);
      int t;
      t = 0;
      while (((sel == 0) ? q4.size() : q100.size()) != 0 && t < 600) begin
         @(negedge clk); #3;
         t++;
      end
      chk("drain_left", 256'((sel == 0) ? q4.size() : q100.size()), 256'(0));
   endtask

   vec_t vecs [0:6];

   initial begin
      int k0, t;
      logic [7:0] hold_key;
      logic [199:0] exp_first;
      exp_t e;

      vecs[0] = '{len: 3,  wsz: 32, exp_keys: 0};
      vecs[1] = '{len: 4,  wsz: 4,  exp_keys: 1};
      vecs[2] = '{len: 1,  wsz: 32, exp_keys: 0};
      vecs[3] = '{len: 40, wsz: 7,  exp_keys: 37};
      vecs[4] = '{len: 33, wsz: 32, exp_keys: 30};
      vecs[5] = '{len: 12, wsz: 3,  exp_keys: 9};
      vecs[6] = '{len: 5,  wsz: 1,  exp_keys: 2};

      set_in(0, 1'b0, 64'd0, 6'd0, 1'b0);
      set_in(1, 1'b0, 64'd0, 6'd0, 1'b0);

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctr4", 256'(ctr4), 256'(0));
      chk("rst_key4", 256'(key4), 256'(0));
      chk("rst_ready4", 256'(if4.in_ready), 256'(0));
      chk("rst_ctr100", 256'(ctr100), 256'(0));
      chk("rst_key100", 256'(key100), 256'(0));
      rst = 1'b1;
      #1;
      chk("ready_before_edge", 256'(if4.in_ready), 256'(0));
      @(negedge clk); #1;
      chk("ready_after_edge", 256'(if4.in_ready), 256'(1));

      // ACGTA with K=4: two known keys, then the marker, then in_ready back high.
      e.ctr = 2'b11; e.key = 200'h1B; q4.push_back(e);
      e.ctr = 2'b11; e.key = 200'h6C; q4.push_back(e);
      e.ctr = 2'b01; e.key = '0;      q4.push_back(e);
      bases[0] = 2'd0; bases[1] = 2'd1; bases[2] = 2'd2; bases[3] = 2'd3; bases[4] = 2'd0;
      drive_read(0, 5, 32);
      drain(0);
      @(negedge clk); #1;
      chk("ready_after_marker", 256'(if4.in_ready), 256'(1));

      // Table of reads on the K=4 instance.
      for (int v = 0; v < 7; v++) begin
         fill_bases(vecs[v].len);
         push_model(0, vecs[v].len);
         k0 = keys4;
         drive_read(0, vecs[v].len, vecs[v].wsz);
         drain(0);
         chk($sformatf("key_count_len%0d", vecs[v].len), 256'(keys4 - k0), 256'(vecs[v].exp_keys));
         if (v == 0) chk("fill_after_short", 256'(u4.fill_q), 256'(0));
      end

      // Back-to-back reads of 6 then 5 bases, no idle gap between them.
      k0 = keys4;
      fill_bases(6);
      push_model(0, 6);
      drive_read(0, 6, 32);
      fill_bases(5);
      push_model(0, 5);
      drive_read(0, 5, 32);
      drain(0);
      chk("b2b_key_count", 256'(keys4 - k0), 256'(5));

      // Stall for 3 cycles while a key is presented.
      k0 = keys4;
      fill_bases(10);
      push_model(0, 10);
      fork
         drive_read(0, 10, 32);
         begin
            t = 0;
            do begin
               @(negedge clk); #1;
               t++;
            end while (ctr4 != 2'b11 && t < 300);
            chk("stall_saw_key", 256'(ctr4), 256'(2'b11));
            stall4   = 1'b1;
            hold_key = key4;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk); #1;
               chk("stall_key", 256'(key4), 256'(hold_key));
               chk("stall_ctr", 256'(ctr4), 256'(2'b11));
               chk("stall_ready", 256'(if4.in_ready), 256'(0));
            end
            stall4 = 1'b0;
         end
      join
      drain(0);
      chk("stall_key_count", 256'(keys4 - k0), 256'(7));

      // Reset in the middle of a 40-base read; no marker for the aborted read.
      k0 = keys4;
      fill_bases(40);
      push_model(0, 40);
      fork
         drive_read(0, 40, 8);
         begin
            t = 0;
            do begin
               @(negedge clk); #1;
               t++;
            end while (keys4 - k0 < 5 && t < 300);
            rst   = 1'b0;
            abort = 1'b1;
            q4.delete();
            q100.delete();
            @(posedge clk);
            @(negedge clk); #1;
            chk("midrst_ctr", 256'(ctr4), 256'(0));
            chk("midrst_key", 256'(key4), 256'(0));
            rst = 1'b1;
            #1;
            chk("midrst_ready_low", 256'(if4.in_ready), 256'(0));
            @(negedge clk); #1;
            chk("midrst_ready_high", 256'(if4.in_ready), 256'(1));
            abort = 1'b0;
         end
      join
      k0 = keys4;
      fill_bases(6);
      push_model(0, 6);
      drive_read(0, 6, 32);
      drain(0);
      chk("post_rst_key_count", 256'(keys4 - k0), 256'(3));

      // Default K=100: 120-base read over words of 32,32,32,24.
      fill_bases(120);
      exp_first = '0;
      for (int i = 0; i < 100; i++) exp_first[199 - 2*i -: 2] = bases[i];
      push_model(1, 120);
      k0 = keys100;
      drive_read(1, 120, 32);
      drain(1);
      chk("k100_key_count", 256'(keys100 - k0), 256'(21));
      chk("k100_first_key", 256'(first100), 256'(exp_first));

      // Idle so that any stray output is caught by the scoreboard.
      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
